// File: rtl/inc_arb_pkg.sv
// Shared definitions for the time-shared Inc16 counter bank.
//   NUM_REQ_MAX : largest supported requester count
//   WIDTH       : counter width, tied to the Inc16 datapath
//   ptr_t       : round-robin pointer / winner index type
//   onehot()    : index -> one-hot vector of NUM_REQ_MAX bits
package inc_arb_pkg;

   localparam int NUM_REQ_MAX = 8;
   localparam int WIDTH       = 16;
   localparam int PTR_W       = $clog2(NUM_REQ_MAX);

   typedef logic [PTR_W-1:0] ptr_t;

   function automatic logic [NUM_REQ_MAX-1:0] onehot(input ptr_t p);
      logic [NUM_REQ_MAX-1:0] v;
      v = '0;
      v[p] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/inc16.sv
// Inc16: 16-bit incrementer with carry out.
//   a    : value to increment
//   sum  : a + 1 (modular)
//   cout : set when a was 16'hFFFF, i.e. the increment wrapped
module inc16
   import inc_arb_pkg::*;
(
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   assign {cout, sum} = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   eligible   : per-requester eligibility this cycle
//   ptr        : index with top priority; scan continues ptr+1, ... wrapping
//   grant_next : one-hot winner (all zero when nothing is eligible)
//   win        : winner index (0 when nothing is eligible)
//   valid      : a winner exists
module rr_arbiter
   import inc_arb_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] eligible,
   input  ptr_t               ptr,
   output logic [NUM_REQ-1:0] grant_next,
   output ptr_t               win,
   output logic               valid
);

   logic [NUM_REQ_MAX-1:0] oh_full;

   always_comb begin
      int idx;
      win   = '0;
      valid = 1'b0;
      idx   = 0;
      // Walk the ring starting at ptr; the first eligible index wins.
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!valid && eligible[idx]) begin
            valid = 1'b1;
            win   = ptr_t'(idx);
         end
      end
   end

   always_comb begin
      oh_full    = onehot(win);
      grant_next = valid ? oh_full[NUM_REQ-1:0] : '0;
   end

endmodule

// File: rtl/inc16_share_arbiter.sv
// inc16_share_arbiter: NUM_REQ 16-bit counters sharing one Inc16.
// A round-robin arbiter picks at most one requester per cycle; its counter
// goes through the single incrementer and is written back on the edge.
// Loads are per counter, all apply in parallel, and take precedence over
// an increment of the same counter (that requester simply waits).
//   clk       : rising-edge clock
//   reset     : asynchronous, active-high reset
//   req       : per-requester increment request, held until granted
//   load      : per-requester synchronous load strobe
//   load_data : load values, requester i at [i*WIDTH +: WIDTH]
//   grant     : registered one-hot pulse, increment of counter i committed
//   wrap      : registered pulse, committed increment went 0xFFFF -> 0x0000
//   count     : counter values, requester i at [i*WIDTH +: WIDTH]
module inc16_share_arbiter
   import inc_arb_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ-1:0]       load,
   input  logic [NUM_REQ*WIDTH-1:0] load_data,
   output logic [NUM_REQ-1:0]       grant,
   output logic [NUM_REQ-1:0]       wrap,
   output logic [NUM_REQ*WIDTH-1:0] count
);

   logic [WIDTH-1:0]   cnt [NUM_REQ];
   ptr_t               ptr;
   ptr_t               win;
   ptr_t               ptr_next;
   logic               valid;
   logic [NUM_REQ-1:0] eligible;
   logic [NUM_REQ-1:0] grant_next;
   logic [WIDTH-1:0]   inc_in;
   logic [WIDTH-1:0]   inc_out;
   logic               inc_cout;

   // A load on the same index wins over its increment; req stays pending.
   assign eligible = req & ~load;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .eligible   (eligible),
      .ptr        (ptr),
      .grant_next (grant_next),
      .win        (win),
      .valid      (valid)
   );

   // NUM_REQ:1 mux feeding the one shared incrementer.
   always_comb begin
      inc_in = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win == ptr_t'(i)) inc_in = cnt[i];
      end
   end

   inc16 u_inc16 (
      .a    (inc_in),
      .sum  (inc_out),
      .cout (inc_cout)
   );

   assign ptr_next = (win == ptr_t'(NUM_REQ - 1)) ? '0 : win + ptr_t'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
         grant <= '0;
         wrap  <= '0;
         ptr   <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (load[i]) begin
               cnt[i] <= load_data[i*WIDTH +: WIDTH];
            end else if (grant_next[i]) begin
               cnt[i] <= inc_out;
            end
         end
         grant <= grant_next;
         wrap  <= inc_cout ? grant_next : '0;
         if (valid) ptr <= ptr_next;
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_count
      assign count[g*WIDTH +: WIDTH] = cnt[g];
   end

endmodule

// File: tb/tb_inc16_share_arbiter.sv
module tb_inc16_share_arbiter;

   localparam int N = 4;
   localparam int W = 16;

   logic           clk;
   logic           reset;
   logic [N-1:0]   req;
   logic [N-1:0]   load;
   logic [N*W-1:0] load_data;
   logic [N-1:0]   grant;
   logic [N-1:0]   wrap;
   logic [N*W-1:0] count;

   int errors;
   int checks;

   inc16_share_arbiter #(
      .NUM_REQ (N)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .load      (load),
      .load_data (load_data),
      .grant     (grant),
      .wrap      (wrap),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] cnt_of(input int i);
      return count[i*W +: W];
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Advance one edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req   = '0;
      load  = '0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      reset     = 1'b1;
      req       = '0;
      load      = '0;
      load_data = '0;
      #12;
      reset = 1'b0;

      // 1: async reset clears a loaded counter immediately
      load = 4'b0001;
      load_data[0*W +: W] = 16'h1234;
      req  = 4'b0010;
      tick();
      load = '0;
      req  = '0;
      check("t1_pre_count0", cnt_of(0), 16'h1234);
      check("t1_pre_grant", grant, 4'b0010);
      #2;
      reset = 1'b1;
      #1;
      check("t1_count0", cnt_of(0), 16'h0000);
      check("t1_count1", cnt_of(1), 16'h0000);
      check("t1_grant", grant, 4'b0000);
      check("t1_wrap", wrap, 4'b0000);
      tick();
      reset = 1'b0;

      // 2: single requester held for three cycles
      req = 4'b0001;
      for (int k = 1; k <= 3; k++) begin
         tick();
         check($sformatf("t2_grant_%0d", k), grant, 4'b0001);
         check($sformatf("t2_count0_%0d", k), cnt_of(0), 32'(k));
      end
      req = '0;
      tick();
      check("t2_grant_idle", grant, 4'b0000);
      check("t2_count0_hold", cnt_of(0), 16'd3);

      // 3: all requesting, round-robin rotation from requester 0
      do_reset();
      req = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         tick();
         check($sformatf("t3_grant_%0d", k), grant, 32'(4'b0001 << (k % 4)));
      end
      req = '0;
      for (int i = 0; i < N; i++)
         check($sformatf("t3_count%0d", i), cnt_of(i), 16'd2);

      // 4: wrap from 0xFFFF
      do_reset();
      load = 4'b0100;
      load_data[2*W +: W] = 16'hFFFF;
      tick();
      load = '0;
      check("t4_load_count2", cnt_of(2), 16'hFFFF);
      check("t4_load_grant", grant, 4'b0000);
      req = 4'b0100;
      tick();
      req = '0;
      check("t4_grant", grant, 4'b0100);
      check("t4_count2", cnt_of(2), 16'h0000);
      check("t4_wrap", wrap, 4'b0100);
      tick();
      check("t4_wrap_clear", wrap, 4'b0000);
      check("t4_grant_clear", grant, 4'b0000);

      // 5: load beats increment on the same index
      do_reset();
      req  = 4'b0011;
      load = 4'b0001;
      load_data[0*W +: W] = 16'h00AA;
      tick();
      load = '0;
      check("t5_count0_load", cnt_of(0), 16'h00AA);
      check("t5_grant1", grant, 4'b0010);
      check("t5_count1", cnt_of(1), 16'h0001);
      check("t5_wrap", wrap, 4'b0000);
      req = 4'b0001;
      tick();
      check("t5_grant0", grant, 4'b0001);
      check("t5_count0_inc", cnt_of(0), 16'h00AB);
      check("t5_count1_hold", cnt_of(1), 16'h0001);
      // lone requester blocked by its own load: no grant at all
      req  = 4'b0001;
      load = 4'b0001;
      load_data[0*W +: W] = 16'h7000;
      tick();
      check("t5_blocked_grant", grant, 4'b0000);
      check("t5_blocked_count0", cnt_of(0), 16'h7000);
      load = '0;
      tick();
      req = '0;
      check("t5_pending_grant", grant, 4'b0001);
      check("t5_pending_count0", cnt_of(0), 16'h7001);

      // 6: reset mid-stream, arbitration restarts at requester 0
      do_reset();
      req = 4'b1111;
      tick();
      check("t6_grant_a", grant, 4'b0001);
      tick();
      check("t6_grant_b", grant, 4'b0010);
      #2;
      reset = 1'b1;
      #1;
      check("t6_grant_in_reset", grant, 4'b0000);
      tick();
      check("t6_grant_held_reset", grant, 4'b0000);
      check("t6_count1_reset", cnt_of(1), 16'h0000);
      reset = 1'b0;
      tick();
      check("t6_first_grant", grant, 4'b0001);
      tick();
      check("t6_second_grant", grant, 4'b0010);
      req = '0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
